// File: rtl/regfile_pkg.sv
// Shared register-file geometry and write-back source indices.
package regfile_pkg;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned REG_DW   = 32;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [REG_AW-1:0] RF_ZERO_ADDR = 5'd0;

  localparam int unsigned WB_SRC_ALU = 0;
  localparam int unsigned WB_SRC_LSU = 1;
  localparam int unsigned WB_SRC_MDU = 2;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_any
);
  localparam int unsigned IW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = (32'(ptr) + off) % NUM_REQ;
      if (!gnt_any && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
        gnt_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of write-back sources onto the single register-file
// write port, with a registered write stage and a saturating contention counter.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned AW      = REG_AW,
  parameter int unsigned DW      = REG_DW,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rf_write_en,
  output logic [AW-1:0]              rf_write_addr,
  output logic [DW-1:0]              rf_write_data,
  output logic [$clog2(NUM_REQ)-1:0] wb_src,
  output logic [CNT_W-1:0]           contention_cnt
);
  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      ptr;
  logic               gnt_any;
  logic               grant;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               contended;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Ready is gated by rst as well so no handshake completes while in reset.
  assign grant     = gnt_any & ~hold & ~rst;
  assign req_ready = grant ? gnt : '0;
  assign contended = ($countones(req_valid) >= 2) && !hold;

  always_comb begin
    sel_addr = req_addr[gnt_idx*AW +: AW];
    sel_data = req_data[gnt_idx*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Address-0 requests are consumed but never raise write_en, keeping r0 constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      wb_src        <= '0;
    end else begin
      rf_write_en <= grant && (sel_addr != AW'(RF_ZERO_ADDR));
      if (grant) begin
        rf_write_addr <= sel_addr;
        rf_write_data <= sel_data;
        wb_src        <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contention_cnt <= '0;
    end else if (contended && (contention_cnt != '1)) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference round-robin model predicts
// grants and write-stage contents; a CNT_W=4 copy exercises counter saturation.
module tb_regfile_wb_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } wb_exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hold = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready, req_ready4;
  logic              rf_write_en, rf_write_en4;
  logic [AW-1:0]     rf_write_addr, rf_write_addr4;
  logic [DW-1:0]     rf_write_data, rf_write_data4;
  logic [1:0]        wb_src, wb_src4;
  logic [15:0]       contention_cnt;
  logic [3:0]        contention_cnt4;

  regfile_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .wb_src(wb_src),
    .contention_cnt(contention_cnt)
  );

  regfile_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready4),
    .rf_write_en(rf_write_en4), .rf_write_addr(rf_write_addr4),
    .rf_write_data(rf_write_data4), .wb_src(wb_src4),
    .contention_cnt(contention_cnt4)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  wb_exp_t       sb[$];
  int unsigned   m_ptr;
  logic [15:0]   m_cnt;
  logic [3:0]    m_cnt4;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  logic [AW-1:0] a_t[N];
  logic [DW-1:0] d_t[N];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr  = 0;
    m_cnt  = '0;
    m_cnt4 = '0;
    m_addr = '0;
    m_data = '0;
    m_src  = '0;
    sb.delete();
  endfunction

  // Entered and left at posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_wen", 64'(rf_write_en), 64'(0));
    check("rst_addr", 64'(rf_write_addr), 64'(0));
    check("rst_data", 64'(rf_write_data), 64'(0));
    check("rst_src", 64'(wb_src), 64'(0));
    check("rst_cnt", 64'(contention_cnt), 64'(0));
    check("rst_cnt4", 64'(contention_cnt4), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One arbitration cycle: drive, predict and check grant, then check the write stage.
  task automatic step(input logic [N-1:0] v, input logic h);
    int      g;
    int      nv;
    wb_exp_t e;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    hold = h;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a_t[i];
      req_data[i*DW +: DW] = d_t[i];
    end
    #1;
    g = -1;
    if (!h) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (int'(m_ptr) + off) % N;
        if (g < 0 && v[k]) g = k;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      m_addr = a_t[g];
      m_data = d_t[g];
      m_src  = 2'(g);
      m_ptr  = (g + 1) % N;
    end
    e.en   = (g >= 0) && (a_t[(g >= 0) ? g : 0] != '0);
    e.addr = m_addr;
    e.data = m_data;
    e.src  = m_src;
    sb.push_back(e);
    nv = $countones(v);
    if (nv >= 2 && !h) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
      if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1'b1;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("wen", 64'(rf_write_en), 64'(e.en));
      check("waddr", 64'(rf_write_addr), 64'(e.addr));
      check("wdata", 64'(rf_write_data), 64'(e.data));
      check("wb_src", 64'(wb_src), 64'(e.src));
    end
    check("cnt", 64'(contention_cnt), 64'(m_cnt));
    check("cnt4", 64'(contention_cnt4), 64'(m_cnt4));
  endtask

  task automatic set_ops(input int seed);
    for (int i = 0; i < N; i++) begin
      a_t[i] = 5'(seed + 3 * i + 1);
      d_t[i] = 32'h1000_0000 * (i + 1) + 32'(seed);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    set_ops(0);
    @(posedge clk);
    #1;
    do_reset();

    // Single request from source 1.
    a_t[1] = 5'd7;
    d_t[1] = 32'hDEADBEEF;
    step(3'b010, 1'b0);
    check("t1_addr", 64'(rf_write_addr), 64'(7));
    check("t1_data", 64'(rf_write_data), 64'hDEADBEEF);
    step(3'b000, 1'b0);

    // All three valid for six cycles from reset.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_ops(c * 7 + 2);
      step(3'b111, 1'b0);
    end
    check("t2_cnt6", 64'(contention_cnt), 64'(6));

    // Address-0 request from source 2 advances ptr to 0 without writing.
    do_reset();
    set_ops(4);
    step(3'b010, 1'b0);
    a_t[2] = 5'd0;
    step(3'b100, 1'b0);
    check("t3_no_wen", 64'(rf_write_en), 64'(0));
    set_ops(9);
    step(3'b011, 1'b0);
    check("t3_src0", 64'(wb_src), 64'(0));

    // Grant to 0, then hold for three cycles with source 1 waiting.
    do_reset();
    set_ops(11);
    step(3'b001, 1'b0);
    for (int c = 0; c < 3; c++) step(3'b010, 1'b1);
    step(3'b010, 1'b0);
    check("t4_src1", 64'(wb_src), 64'(1));

    // Reset asserted with the write stage loaded.
    do_reset();
    set_ops(13);
    step(3'b111, 1'b0);
    step(3'b110, 1'b0);
    check("t5_loaded", 64'(rf_write_en), 64'(1));
    do_reset();
    step(3'b111, 1'b0);
    check("t5_restart", 64'(wb_src), 64'(0));

    // Saturation of the narrow counter.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      set_ops(c);
      step(3'b011, 1'b0);
    end
    check("t6_sat15", 64'(contention_cnt4), 64'(15));
    check("t6_cnt20", 64'(contention_cnt), 64'(20));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        a_t[i] = 5'($urandom_range(0, 31));
        d_t[i] = $urandom;
      end
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
